// File: rtl/seg_writer_rtc_pkg.sv
// ============================================================================
// Module   : seg_writer_rtc_pkg
// Brief    : Shared constants and BCD helper for the RTC seconds writer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seg_writer_rtc_pkg;

    // Bus-phase states are numbered in order so a phase can advance by +1.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_ALAT = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    localparam logic [7:0] ADDR_SEG_DEFAULT = 8'h21;
    localparam logic [7:0] BCD_MAX          = 8'h59;

    function automatic logic bcd_sec_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_writer_rtc_bcd_mod60_updown.sv
// ============================================================================
// Module   : bcd_mod60_updown
// Brief    : Next BCD seconds value: validated load, or increment/decrement mod 60.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_mod60_updown
    import seg_writer_rtc_pkg::*;
(
    input  logic [7:0] cur_i,
    input  logic [7:0] load_val_i,
    input  logic       load_i,
    input  logic       up_i,
    input  logic       down_i,
    output logic [7:0] next_o
);

    logic [3:0] w_hi;
    logic [3:0] w_lo;

    assign w_hi = cur_i[7:4];
    assign w_lo = cur_i[3:0];

    always_comb begin
        next_o = cur_i;
        if (load_i) begin
            next_o = bcd_sec_valid(load_val_i) ? load_val_i : 8'h00;
        end else if (up_i && !down_i) begin
            if (cur_i == BCD_MAX)
                next_o = 8'h00;
            else if (w_lo == 4'd9)
                next_o = {w_hi + 4'd1, 4'd0};
            else
                next_o = {w_hi, w_lo + 4'd1};
        end else if (down_i && !up_i) begin
            if (cur_i == 8'h00)
                next_o = BCD_MAX;
            else if (w_lo == 4'd0)
                next_o = {w_hi - 4'd1, 4'd9};
            else
                next_o = {w_hi, w_lo - 4'd1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg_writer_rtc.sv
// ============================================================================
// Module   : seg_writer_rtc
// Brief    : Seconds editor with multiplexed-bus RTC write sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_writer_rtc
    import seg_writer_rtc_pkg::*;
#(
    parameter logic [7:0] ADDR_SEG = ADDR_SEG_DEFAULT,
    parameter int         T_PHASE  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       seleccion,
    input  logic [7:0] dato_seg_in,
    input  logic       up,
    input  logic       down,
    input  logic       confirm,
    output logic [7:0] seg_edit,
    output logic       ACT,
    output logic       busy,
    output logic       done,
    output logic       cs_n,
    output logic       ale,
    output logic       wr_n,
    output logic [7:0] ad_out,
    output logic       ad_oe
);

    localparam logic [3:0] C_LAST = 4'(T_PHASE - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic [7:0] seg_q, seg_d;
    logic       act_q;
    logic       sel_q, armed_q;
    logic       busy_q, done_q;
    logic       cs_n_q, ale_q, wr_n_q, ad_oe_q;
    logic [7:0] ad_out_q;
    logic       cs_n_d, ale_d, wr_n_d, ad_oe_d;
    logic [7:0] ad_out_d;

    logic w_busy, w_rise, w_step, w_start;

    assign w_busy  = (state_q != ST_IDLE);
    // armed_q keeps a level already high at reset release from looking like an edge.
    assign w_rise  = armed_q && seleccion && !sel_q;
    assign w_step  = seleccion && !w_busy && (up ^ down);
    assign w_start = confirm && seleccion && !w_busy;

    bcd_mod60_updown u_bcd (
        .cur_i      (seg_q),
        .load_val_i (dato_seg_in),
        .load_i     (w_rise),
        .up_i       (w_step && up),
        .down_i     (w_step && down),
        .next_o     (seg_d)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    state_d = ST_ADDR;
                    cnt_d   = 4'd0;
                    data_d  = seg_q;
                end
            end
            ST_ADDR, ST_ALAT, ST_DATA, ST_HOLD: begin
                if (cnt_q == C_LAST) begin
                    state_d = state_q + 3'd1;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state and registered.
    always_comb begin
        cs_n_d   = 1'b1;
        ale_d    = 1'b0;
        wr_n_d   = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = 8'h00;
        case (state_d)
            ST_ADDR: begin
                cs_n_d = 1'b0; ale_d = 1'b1; ad_oe_d = 1'b1; ad_out_d = ADDR_SEG;
            end
            ST_ALAT: begin
                cs_n_d = 1'b0; ad_oe_d = 1'b1; ad_out_d = ADDR_SEG;
            end
            ST_DATA: begin
                cs_n_d = 1'b0; wr_n_d = 1'b0; ad_oe_d = 1'b1; ad_out_d = data_d;
            end
            ST_HOLD: begin
                cs_n_d = 1'b0; ad_oe_d = 1'b1; ad_out_d = data_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            data_q   <= 8'h00;
            seg_q    <= 8'h00;
            act_q    <= 1'b0;
            sel_q    <= 1'b0;
            armed_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            ale_q    <= 1'b0;
            wr_n_q   <= 1'b1;
            ad_oe_q  <= 1'b0;
            ad_out_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            seg_q    <= seg_d;
            act_q    <= w_rise || w_step;
            sel_q    <= seleccion;
            armed_q  <= 1'b1;
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= (state_d == ST_DONE);
            cs_n_q   <= cs_n_d;
            ale_q    <= ale_d;
            wr_n_q   <= wr_n_d;
            ad_oe_q  <= ad_oe_d;
            ad_out_q <= ad_out_d;
        end
    end

    assign seg_edit = seg_q;
    assign ACT      = act_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cs_n     = cs_n_q;
    assign ale      = ale_q;
    assign wr_n     = wr_n_q;
    assign ad_oe    = ad_oe_q;
    assign ad_out   = ad_out_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_writer_rtc.sv
// ============================================================================
// Module   : tb_seg_writer_rtc
// Brief    : Self-checking bench for seg_writer_rtc against a seconds/bus model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg_writer_rtc;

    localparam int         T    = 4;
    localparam logic [7:0] ADDR = 8'h21;

    logic       clk = 1'b0;
    logic       reset;
    logic       seleccion, up, down, confirm;
    logic [7:0] dato_seg_in;
    logic [7:0] seg_edit, ad_out;
    logic       ACT, busy, done, cs_n, ale, wr_n, ad_oe;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: seconds as an integer, write progress as a cycle index.
    int   m_sec;
    int   m_k;
    logic [7:0] m_data;
    logic m_act, m_prev_sel, m_armed;

    always #5 clk = ~clk;

    seg_writer_rtc #(.ADDR_SEG(ADDR), .T_PHASE(T)) dut (
        .clk(clk), .reset(reset), .seleccion(seleccion), .dato_seg_in(dato_seg_in),
        .up(up), .down(down), .confirm(confirm), .seg_edit(seg_edit), .ACT(ACT),
        .busy(busy), .done(done), .cs_n(cs_n), .ale(ale), .wr_n(wr_n),
        .ad_out(ad_out), .ad_oe(ad_oe)
    );

    function automatic logic [7:0] to_bcd(input int s);
        return 8'(((s / 10) * 16) + (s % 10));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sec = 0; m_k = 0; m_data = 8'h00; m_act = 1'b0; m_armed = 1'b0; m_prev_sel = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic u, input logic d, input logic c,
                              input logic [7:0] dat);
        bit busy_now;
        int hi, lo, cap;
        busy_now = (m_k != 0);
        hi  = int'(dat) / 16;
        lo  = int'(dat) % 16;
        cap = m_sec;
        m_act = 1'b0;
        if (m_armed && s && !m_prev_sel) begin
            m_sec = (hi <= 5 && lo <= 9) ? hi * 10 + lo : 0;
            m_act = 1'b1;
        end else if (s && !busy_now && (u != d)) begin
            m_sec = u ? (m_sec + 1) % 60 : (m_sec + 59) % 60;
            m_act = 1'b1;
        end
        if (m_k == 4 * T + 1)      m_k = 0;
        else if (m_k != 0)         m_k = m_k + 1;
        else if (c && s) begin
            m_k = 1;
            m_data = to_bcd(cap);
        end
        m_prev_sel = s;
        m_armed = 1'b1;
    endtask

    task automatic check_outputs();
        logic [5:0] e;   // {busy, done, cs_n, ale, wr_n, ad_oe}
        logic [7:0] ead;
        int ph;
        e = 6'b001010; ead = 8'h00;
        if (m_k == 4 * T + 1) begin
            e = 6'b111010;
        end else if (m_k != 0) begin
            ph  = (m_k - 1) / T;
            ead = (ph < 2) ? ADDR : m_data;
            e   = {1'b1, 1'b0, 1'b0, ph == 0, ph != 2, 1'b1};
        end
        chk("seg_edit", 32'(seg_edit), 32'(to_bcd(m_sec)));
        chk("ACT", 32'(ACT), 32'(m_act));
        chk("ctl{busy,done,cs_n,ale,wr_n,ad_oe}", 32'({busy, done, cs_n, ale, wr_n, ad_oe}), 32'(e));
        if (m_k != 4 * T + 1) chk("ad_out", 32'(ad_out), 32'(ead));
    endtask

    task automatic cyc(input logic s, input logic u, input logic d, input logic c,
                       input logic [7:0] dat);
        seleccion = s; up = u; down = d; confirm = c; dato_seg_in = dat;
        @(posedge clk); #1;
        model_step(s, u, d, c, dat);
        check_outputs();
    endtask

    typedef struct {
        logic [7:0] dato;
        logic       u;
        logic       d;
        logic [7:0] exp_load;
        logic [7:0] exp_seg;
        logic       exp_act;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{8'h37, 1'b0, 1'b0, 8'h37, 8'h37, 1'b0};
        vecs[1]  = '{8'h7A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{8'h59, 1'b1, 1'b0, 8'h59, 8'h00, 1'b1};
        vecs[3]  = '{8'h00, 1'b0, 1'b1, 8'h00, 8'h59, 1'b1};
        vecs[4]  = '{8'h59, 1'b0, 1'b1, 8'h59, 8'h58, 1'b1};
        vecs[5]  = '{8'h09, 1'b1, 1'b0, 8'h09, 8'h10, 1'b1};
        vecs[6]  = '{8'h10, 1'b0, 1'b1, 8'h10, 8'h09, 1'b1};
        vecs[7]  = '{8'h42, 1'b1, 1'b1, 8'h42, 8'h42, 1'b0};
        vecs[8]  = '{8'h60, 1'b1, 1'b0, 8'h00, 8'h01, 1'b1};
        vecs[9]  = '{8'hA5, 1'b0, 1'b1, 8'h00, 8'h59, 1'b1};
        vecs[10] = '{8'h2F, 1'b1, 1'b0, 8'h00, 8'h01, 1'b1};

        seleccion = 1'b0; up = 1'b0; down = 1'b0; confirm = 1'b0; dato_seg_in = 8'h00;
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(0, 0, 0, 0, 8'h00);

        // Table: load on rising seleccion, then one up/down action.
        for (int i = 0; i < 11; i++) begin
            cyc(0, 0, 0, 0, vecs[i].dato);
            cyc(1, 0, 0, 0, vecs[i].dato);
            chk("tbl_load", 32'(seg_edit), 32'(vecs[i].exp_load));
            chk("tbl_load_act", 32'(ACT), 32'd1);
            cyc(1, vecs[i].u, vecs[i].d, 0, vecs[i].dato);
            chk("tbl_seg", 32'(seg_edit), 32'(vecs[i].exp_seg));
            chk("tbl_act", 32'(ACT), 32'(vecs[i].exp_act));
            cyc(1, 0, 0, 0, vecs[i].dato);
            chk("tbl_act_off", 32'(ACT), 32'd0);
        end

        // Full write of 8'h42 with ignored up pulses and a second confirm.
        cyc(0, 0, 0, 0, 8'h42);
        cyc(1, 0, 0, 0, 8'h42);
        begin
            int lat;
            lat = 0;
            cyc(1, 0, 0, 1, 8'h42);
            lat = 1;
            while (done !== 1'b1 && lat < 40) begin
                cyc(1, lat % 3 == 0, 1'b0, lat == 5, 8'h42);
                lat++;
            end
            chk("write_latency", 32'(lat), 32'(4 * T + 1));
            chk("seg_after_busy_up", 32'(seg_edit), 32'h42);
            cyc(1, 0, 0, 0, 8'h42);
            chk("busy_after_done", 32'(busy), 32'd0);
        end

        // seleccion dropping mid-write does not abort the write.
        cyc(1, 0, 0, 1, 8'h13);
        for (int k = 0; k < 4 * T + 2; k++) cyc(k < 3, 0, 0, 0, 8'h13);
        chk("sel_drop_seg_kept", 32'(seg_edit), 32'h42);

        // Asynchronous reset during the DATA phase, with seleccion held high.
        cyc(0, 0, 0, 0, 8'h25);
        cyc(1, 0, 0, 0, 8'h25);
        cyc(1, 0, 0, 1, 8'h25);
        for (int k = 0; k < 2 * T; k++) cyc(1, 0, 0, 0, 8'h25);
        chk("in_data_wr_n", 32'(wr_n), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_wr_n", 32'(wr_n), 32'd1);
        chk("rst_ad_oe", 32'(ad_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        check_outputs();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 8'h37);
        chk("no_edge_after_reset", 32'(seg_edit), 32'h00);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
